// File: rtl/gpio_controller_if.sv
// Bus-side interface of the GPIO block: chip-select, write strobe, word address and data.
interface gpio_controller_if #(
   parameter int unsigned ADDR_WIDTH = 5
) ();
   logic                  chip_select;
   logic                  we;
   logic [ADDR_WIDTH-1:0] address;
   logic [31:0]           data_in;
   logic [31:0]           data_out;

   modport master (
      output chip_select,
      output we,
      output address,
      output data_in,
      input  data_out
   );

   modport slave (
      input  chip_select,
      input  we,
      input  address,
      input  data_in,
      output data_out
   );
endinterface

// File: rtl/gpio_controller.sv
// Memory-mapped bidirectional GPIO with per-pin direction, input synchronisers,
// atomic set/clear of the output register and sticky edge-triggered interrupts.
module gpio_controller #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ADDR_WIDTH  = 5
) (
   input  logic                 clock,
   input  logic                 reset_n,
   gpio_controller_if.slave     bus,
   input  logic [WIDTH-1:0]     io_in,
   output logic [WIDTH-1:0]     io_out,
   output logic [WIDTH-1:0]     io_oe,
   output logic                 irq
);

   localparam logic [ADDR_WIDTH-1:0] AddrOut    = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] AddrDir    = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] AddrIn     = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] AddrRiseEn = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] AddrFallEn = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] AddrStatus = ADDR_WIDTH'(5);
   localparam logic [ADDR_WIDTH-1:0] AddrSet    = ADDR_WIDTH'(6);
   localparam logic [ADDR_WIDTH-1:0] AddrClr    = ADDR_WIDTH'(7);

   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] rise_en_q, rise_en_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d;
   logic [WIDTH-1:0] status_q, status_d;
   logic [WIDTH-1:0] prev_q;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

   logic [WIDTH-1:0] sync_last;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] edge_set;
   logic [WIDTH-1:0] w1c;
   logic [WIDTH-1:0] rdata;
   logic             wr_en;

   assign sync_last = sync_q[SYNC_STAGES-1];
   assign wdata     = bus.data_in[WIDTH-1:0];
   assign wr_en     = bus.chip_select & bus.we;
   assign edge_set  = (sync_last & ~prev_q & rise_en_q) | (~sync_last & prev_q & fall_en_q);

   generate
      if (WIDTH < 32) begin : g_unused_wdata
         logic unused_wdata;
         assign unused_wdata = ^bus.data_in[31:WIDTH];
      end
   endgenerate

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], io_in};
      out_d     = out_q;
      dir_d     = dir_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      w1c       = '0;
      if (wr_en) begin
         case (bus.address)
            AddrOut:    out_d     = wdata;
            AddrDir:    dir_d     = wdata;
            AddrRiseEn: rise_en_d = wdata;
            AddrFallEn: fall_en_d = wdata;
            AddrStatus: w1c       = wdata;
            AddrSet:    out_d     = out_q | wdata;
            AddrClr:    out_d     = out_q & ~wdata;
            default:    ;
         endcase
      end
      // A new edge event outranks a simultaneous clear of the same bit.
      status_d = (status_q & ~w1c) | edge_set;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         out_q     <= '0;
         dir_q     <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         prev_q    <= '0;
         sync_q    <= '0;
      end else begin
         out_q     <= out_d;
         dir_q     <= dir_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         status_q  <= status_d;
         prev_q    <= sync_last;
         sync_q    <= sync_d;
      end
   end

   always_comb begin
      rdata = '0;
      if (bus.chip_select) begin
         case (bus.address)
            AddrOut:    rdata = out_q;
            AddrDir:    rdata = dir_q;
            AddrIn:     rdata = sync_last;
            AddrRiseEn: rdata = rise_en_q;
            AddrFallEn: rdata = fall_en_q;
            AddrStatus: rdata = status_q;
            default:    rdata = '0;
         endcase
      end
   end

   assign bus.data_out = 32'(rdata);
   assign io_out       = out_q;
   assign io_oe        = dir_q;
   assign irq          = |status_q;

endmodule

// File: tb/tb_gpio_controller.sv
// Self-checking bench for gpio_controller: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a sample-history reference model.
module tb_gpio_controller;

   localparam int unsigned W  = 4;
   localparam int unsigned S  = 2;
   localparam int unsigned AW = 5;

   logic         clock   = 1'b0;
   logic         reset_n = 1'b0;
   logic [W-1:0] io_in   = '0;
   logic [W-1:0] io_out;
   logic [W-1:0] io_oe;
   logic         irq;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   gpio_controller_if #(.ADDR_WIDTH(AW)) bus ();

   gpio_controller #(
      .WIDTH      (W),
      .SYNC_STAGES(S),
      .ADDR_WIDTH (AW)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus),
      .io_in  (io_in),
      .io_out (io_out),
      .io_oe  (io_oe),
      .irq    (irq)
   );

   always #5 clock = ~clock;

   // Reference model: register file plus a history of pin samples (smp[0] = newest).
   logic [W-1:0] m_out, m_dir, m_re, m_fe, m_st;
   logic [W-1:0] smp [0:S];

   always @(posedge clock) begin : model
      logic [W-1:0] d, last, prv, ev, w1c;
      if (!reset_n) begin
         m_out = '0; m_dir = '0; m_re = '0; m_fe = '0; m_st = '0;
         for (int i = 0; i <= S; i++) smp[i] = '0;
      end else begin
         d    = bus.data_in[W-1:0];
         last = smp[S-1];
         prv  = smp[S];
         ev   = (last & ~prv & m_re) | (~last & prv & m_fe);
         w1c  = '0;
         if (bus.chip_select && bus.we) begin
            case (bus.address)
               5'd0: m_out = d;
               5'd1: m_dir = d;
               5'd3: m_re  = d;
               5'd4: m_fe  = d;
               5'd5: w1c   = d;
               5'd6: m_out = m_out | d;
               5'd7: m_out = m_out & ~d;
               default: ;
            endcase
         end
         m_st = (m_st & ~w1c) | ev;
         for (int i = S; i > 0; i--) smp[i] = smp[i-1];
         smp[0] = io_in;
      end
   end

   function automatic logic [31:0] m_read();
      if (!bus.chip_select) return 32'h0;
      case (bus.address)
         5'd0: return 32'(m_out);
         5'd1: return 32'(m_dir);
         5'd2: return 32'(smp[S-1]);
         5'd3: return 32'(m_re);
         5'd4: return 32'(m_fe);
         5'd5: return 32'(m_st);
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (cmp_en) begin
         chk("model_io_out", 32'(io_out), 32'(m_out));
         chk("model_io_oe", 32'(io_oe), 32'(m_dir));
         chk("model_irq", 32'(irq), 32'(|m_st));
         chk("model_data_out", bus.data_out, m_read());
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
      bus.chip_select = 1'b1;
      bus.we          = 1'b1;
      bus.address     = a;
      bus.data_in     = d;
      cyc();
      bus.we          = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
      bus.chip_select = 1'b1;
      bus.we          = 1'b0;
      bus.address     = a;
      #1;
      chk(name, bus.data_out, exp);
   endtask

   initial begin
      bus.chip_select = 1'b0;
      bus.we          = 1'b0;
      bus.address     = '0;
      bus.data_in     = '0;

      // Reset with all pins high
      reset_n = 1'b0;
      io_in   = 4'hF;
      cyc();
      cmp_en = 1'b1;
      cyc();
      chk("rst_io_out", 32'(io_out), 32'h0);
      chk("rst_io_oe", 32'(io_oe), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      reset_n = 1'b1;
      rd_chk("rst_in_before", 5'd2, 32'h0);
      cyc();
      rd_chk("rst_in_r0", 5'd2, 32'h0);
      cyc();
      rd_chk("rst_in_r1", 5'd2, 32'hF);
      for (int a = 0; a < 8; a++) begin
         if (a != 2) rd_chk("rst_reg_zero", AW'(a), 32'h0);
         cyc();
      end
      chk("rst_status_irq", 32'(irq), 32'h0);

      // Set / clear
      wr(5'd0, 32'h5);
      chk("out_write", 32'(io_out), 32'h5);
      wr(5'd6, 32'h2);
      chk("out_set", 32'(io_out), 32'h7);
      wr(5'd7, 32'h4);
      chk("out_clr", 32'(io_out), 32'h3);
      wr(5'd0, 32'hFFFF_FFF0);
      chk("out_high_bits", 32'(io_out), 32'h0);

      // Rising interrupt on pin 0 (pins already high: enabling must not create an event)
      wr(5'd3, 32'h1);
      io_in = 4'h0;
      repeat (4) cyc();
      rd_chk("rise_quiet", 5'd5, 32'h0);
      io_in = 4'h1;
      cyc();
      chk("rise_k", 32'(irq), 32'h0);
      cyc();
      chk("rise_k1", 32'(irq), 32'h0);
      cyc();
      chk("rise_k2_irq", 32'(irq), 32'h1);
      rd_chk("rise_k2_status", 5'd5, 32'h1);
      wr(5'd5, 32'h1);
      chk("w1c_irq", 32'(irq), 32'h0);
      rd_chk("w1c_status", 5'd5, 32'h0);

      // Falling edge on pin 3 only; rise on pin 2 masked
      wr(5'd3, 32'h0);
      wr(5'd4, 32'h8);
      io_in = 4'h9;
      repeat (4) cyc();
      io_in = 4'h1;
      repeat (4) cyc();
      io_in = 4'h9;
      repeat (4) cyc();
      io_in = 4'hD;
      repeat (4) cyc();
      rd_chk("fall_status", 5'd5, 32'h8);
      chk("fall_irq", 32'(irq), 32'h1);
      wr(5'd5, 32'h8);
      rd_chk("fall_cleared", 5'd5, 32'h0);
      wr(5'd4, 32'h0);

      // Collision: W1C lands on the detection edge of a new rise
      wr(5'd3, 32'h1);
      io_in = 4'hC;
      repeat (4) cyc();
      io_in = 4'hD;
      cyc();
      cyc();
      wr(5'd5, 32'h1);
      chk("coll_irq", 32'(irq), 32'h1);
      rd_chk("coll_status", 5'd5, 32'h1);
      wr(5'd5, 32'h1);
      rd_chk("coll_cleared", 5'd5, 32'h0);
      wr(5'd3, 32'h0);

      // Decode
      wr(5'd0, 32'h5);
      bus.chip_select = 1'b0;
      bus.we          = 1'b1;
      bus.address     = 5'd0;
      bus.data_in     = 32'hA;
      cyc();
      chk("dec_cs0_out", 32'(io_out), 32'h5);
      chk("dec_cs0_rd", bus.data_out, 32'h0);
      bus.we = 1'b0;
      wr(5'd12, 32'hFFFF_FFFF);
      chk("dec_off12_wr", 32'(io_out), 32'h5);
      rd_chk("dec_off12_rd", 5'd12, 32'h0);
      rd_chk("dec_off0_rd", 5'd0, 32'h5);
      cyc();

      // Randomized traffic with occasional resets
      repeat (3000) begin
         reset_n         = ($urandom_range(0, 299) != 0);
         bus.chip_select = ($urandom_range(0, 3) != 0);
         bus.we          = ($urandom_range(0, 1) != 0);
         bus.address     = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(8, 31))
                                                       : AW'($urandom_range(0, 7));
         bus.data_in     = $urandom;
         if ($urandom_range(0, 3) == 0) io_in = W'($urandom);
         cyc();
      end

      reset_n         = 1'b1;
      bus.chip_select = 1'b0;
      bus.we          = 1'b0;
      repeat (2) cyc();
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpio_controller.md
# gpio_controller

Parametrised, memory-mapped bidirectional GPIO block with 1–32 channels, per-pin direction control, input synchronisation, and edge-triggered interrupts. It occupies the I/O window of the memory controller (word addresses 0x0020–0x003F) and is selected by the controller's I/O chip-select. It provides registered outputs, atomic set/clear and sticky edge status that the fixed 4-bit write-only I/O port lacks.

## Interface

Parameters:
- WIDTH, 4, number of GPIO channels; legal range 1–32.
- SYNC_STAGES, 2, input synchroniser depth; legal range 2–3.
- ADDR_WIDTH, 5, word-offset bits decoded within the I/O window.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- chip_select  in  1  block selected by the memory controller.
- we  in  1  write enable; a write occurs when chip_select && we at a rising edge.
- address  in  ADDR_WIDTH  word offset within the window.
- data_in  in  32  write data.
- data_out  out  32  read data; combinational from address and registers.
- io_in  in  WIDTH  asynchronous pin inputs.
- io_out  out  WIDTH  pin output values; equal to the OUT register.
- io_oe  out  WIDTH  per-pin output enable; equal to the DIR register (1 = drive).
- irq  out  1  interrupt; equal to the OR of all STATUS bits.

## Operation

Register map (word offsets):
- 0 OUT: read/write.
- 1 DIR: read/write.
- 2 IN: read-only; last synchroniser stage.
- 3 RISE_EN: read/write.
- 4 FALL_EN: read/write.
- 5 STATUS: read; write-1-to-clear.
- 6 SET: write-only; OUT <= OUT | data. Reads 0.
- 7 CLR: write-only; OUT <= OUT & ~data. Reads 0.
- Offsets 8 and above read 0 and ignore writes.

Data width rules:
- Write data bits at WIDTH and above are ignored.
- Reads are zero-extended to 32 bits.
- data_out returns 0 when chip_select is low.

Input path:
- io_in passes through a SYNC_STAGES flop chain, then a single "prev" flop.
- rise[i] = sync_last[i] & ~prev[i]; fall[i] = ~sync_last[i] & prev[i].
- STATUS[i] sets when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- IN reflects synchronised pin state for all pins, regardless of DIR.

STATUS behaviour:
- STATUS bits are sticky; only a W1C write or reset clears them.
- If a W1C write and a set event hit the same bit in the same cycle, set wins.

Enable semantics:
- Enables are sampled in the detection cycle.
- Enabling RISE_EN on a pin that is already high does not create an event.

Reset (reset_n low at a rising edge):
- OUT, DIR, RISE_EN, FALL_EN, STATUS, all synchroniser and prev flops clear to 0.
- Outputs after reset: io_out = 0, io_oe = 0, irq = 0.
- Reset asserted mid-operation discards pending edges and any in-flight write.
- Because enables are 0 after reset, a pin high at reset release produces no STATUS bit.

## Timing

- Write: takes effect at the rising edge where chip_select && we is high. The new value appears on io_out/io_oe and on read-back in the following cycle.
- Read: data_out is valid in the same cycle as address/chip_select, with zero wait states.
- Input latency: a pin change first captured at rising edge k is visible in IN after edge k+SYNC_STAGES−1.
- STATUS latency: the corresponding STATUS bit sets at edge k+SYNC_STAGES.
- irq latency: irq rises in the same cycle as the STATUS bit (no extra delay).
- Glitches shorter than one clock period that are not sampled produce no event.
- A pulse held for at least one sampled edge produces both a rise event and a fall event if both are enabled.

## Test plan

All scenarios use WIDTH=4, SYNC_STAGES=2.

- Reset: hold reset_n low for 2 cycles with io_in=4'hF -> io_out=0, io_oe=0, irq=0. All offsets 0–7 read 0 except IN, which reads 4'hF two cycles after release. STATUS stays 0.
- Set/clear: write OUT=0x5, then SET=0x2, then CLR=0x4 -> io_out reads 0x5, 0x7, 0x3 on successive cycles. A write of 0xFFFF_FFF0 to OUT leaves io_out=0.
- Rising interrupt: RISE_EN=0x1; io_in[0] goes 0→1 before edge k -> STATUS=0x1 and irq=1 from edge k+2. A W1C write of 0x1 clears both on the next edge.
- Falling edge and masking: FALL_EN=0x8, RISE_EN=0; toggle io_in[3] 1→0→1 -> exactly one STATUS bit (0x8) sets. A rise on io_in[2] sets nothing.
- Collision: write STATUS=0x1 in the same cycle a new bit-0 rise event is detected -> STATUS[0] remains 1 and irq stays 1.
- Decode: chip_select=0 with we=1 and address 0 -> OUT unchanged and data_out=0. A read of offset 12 with chip_select=1 returns 0.
